// File: rtl/membus_arbiter.sv
// Round-robin arbiter sharing one memory data port between two masters; a fixed-latency
// owner pipeline steers each read return back to the master that issued it.
module membus_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned READ_LAT = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,

    input  logic          i_m0_req,
    input  logic          i_m0_we,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_wdata,
    output logic          o_m0_gnt,
    output logic          o_m0_rvalid,
    output logic [DW-1:0] o_m0_rdata,

    input  logic          i_m1_req,
    input  logic          i_m1_we,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_wdata,
    output logic          o_m1_gnt,
    output logic          o_m1_rvalid,
    output logic [DW-1:0] o_m1_rdata,

    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,

    output logic          o_busy
);

    logic                r_m0_gnt;
    logic                r_m1_gnt;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [AW-1:0]       r_mem_addr;
    logic [DW-1:0]       r_mem_wdata;
    logic                r_rr;  // 1 = m1 wins when both are eligible
    logic [READ_LAT-1:0] r_pipe_vld;
    logic [READ_LAT-1:0] r_pipe_own;

    logic                w_elig0;
    logic                w_elig1;
    logic                w_any;
    logic                w_win;
    logic                w_win_we;
    logic [AW-1:0]       w_win_addr;
    logic [DW-1:0]       w_win_wdata;
    logic                w_ret_vld;
    logic                w_ret_own;

    // A master whose grant is visible this cycle is still presenting the request just issued.
    always_comb begin
        w_elig0 = i_m0_req & ~r_m0_gnt;
        w_elig1 = i_m1_req & ~r_m1_gnt;
        w_any   = w_elig0 | w_elig1;
        if (w_elig0 && w_elig1) begin
            w_win = r_rr;
        end else begin
            w_win = w_elig1;
        end
        w_win_we    = w_win ? i_m1_we    : i_m0_we;
        w_win_addr  = w_win ? i_m1_addr  : i_m0_addr;
        w_win_wdata = w_win ? i_m1_wdata : i_m0_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_m0_gnt    <= 1'b0;
            r_m1_gnt    <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rr        <= 1'b0;
        end else begin
            r_m0_gnt <= w_any & ~w_win;
            r_m1_gnt <= w_any & w_win;
            r_mem_en <= w_any;
            r_mem_we <= w_any & w_win_we;
            if (w_any) begin
                r_mem_addr  <= w_win_addr;
                r_mem_wdata <= w_win_wdata;
                r_rr        <= ~w_win;
            end
        end
    end

    // Owner tag enters at the end of the issue cycle and exits when mem_rdata is valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pipe_vld <= '0;
            r_pipe_own <= '0;
        end else begin
            r_pipe_vld[0] <= r_mem_en & ~r_mem_we;
            r_pipe_own[0] <= r_m1_gnt;
            for (int i = 1; i < int'(READ_LAT); i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_own[i] <= r_pipe_own[i-1];
            end
        end
    end

    always_comb begin
        w_ret_vld = r_pipe_vld[READ_LAT-1];
        w_ret_own = r_pipe_own[READ_LAT-1];
    end

    assign o_m0_gnt    = r_m0_gnt;
    assign o_m1_gnt    = r_m1_gnt;
    assign o_m0_rvalid = w_ret_vld & ~w_ret_own;
    assign o_m1_rvalid = w_ret_vld & w_ret_own;
    assign o_m0_rdata  = i_mem_rdata;
    assign o_m1_rdata  = i_mem_rdata;
    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = |r_pipe_vld;

endmodule
